karatsuba_dispatch: RTL and testbench

Operand dispatcher sitting directly upstream of the 8x8 Karatsuba multiplier. It buffers incoming operand pairs in a small FIFO and drives the multiplier's START/LOADA/LOADB inputs one transaction at a time. It captures RES when DONE arrives and presents each 16-bit product on a valid/ready output port in issue order. It decouples bursty producers from the multiplier's multi-cycle, single-outstanding protocol.

---
 rtl/karatsuba_dispatch_if.sv | 33 +++
 rtl/karatsuba_dispatch.sv | 161 ++++++++++++++++
 tb/tb_karatsuba_dispatch.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/karatsuba_dispatch_if.sv
// Operand-dispatch bundle: producer push port, multiplier control/result, product port, status.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready handshakes live here; master modport is the dispatcher side.
interface karatsuba_dispatch_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_a;
   logic [7:0]    in_b;
   logic          mul_start;
   logic [7:0]    mul_a;
   logic [7:0]    mul_b;
   logic [15:0]   mul_res;
   logic          mul_done;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   out_res;
   logic [CW-1:0] count;
   logic          err;

   modport master (
      input  in_valid, in_a, in_b, mul_res, mul_done, out_ready,
      output in_ready, mul_start, mul_a, mul_b, out_valid, out_res, count, err
   );

   modport slave (
      output in_valid, in_a, in_b, mul_res, mul_done, out_ready,
      input  in_ready, mul_start, mul_a, mul_b, out_valid, out_res, count, err
   );
endinterface

// File: rtl/karatsuba_dispatch.sv
// Queues 8x8 operand pairs and runs them one at a time through the Karatsuba multiplier.
// Latency: push->start 2 edges, DONE->out_valid 1 edge, accept->next pop 1 edge.
// Backpressure: in_ready = !full; product held in HOLD until out_ready. Macro KARATSUBA_DISPATCH_TIMEOUT_EN adds a WAIT watchdog.
module karatsuba_dispatch #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   karatsuba_dispatch_if.master bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   state_t        state_q, state_d;
   logic [15:0]   mem_q [DEPTH];
   logic [15:0]   mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [7:0]    mul_a_q, mul_a_d;
   logic [7:0]    mul_b_q, mul_b_d;
   logic          out_valid_q, out_valid_d;
   logic [15:0]   out_res_q, out_res_d;
   logic          in_ready;
   logic          push;
   logic          pop;

`ifdef KARATSUBA_DISPATCH_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] timer_q, timer_d;
   logic          err_q, err_d;
`endif

   // Full is the only thing that stalls the producer; no bypass into the multiplier.
   assign in_ready = (count_q != CW'(DEPTH));

   // Next-state: FIFO bookkeeping plus the single-outstanding issue sequencer.
   always_comb begin
      state_d     = state_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      out_valid_d = out_valid_q;
      out_res_d   = out_res_q;
      push        = bus.in_valid && in_ready;
      pop         = 1'b0;
`ifdef KARATSUBA_DISPATCH_TIMEOUT_EN
      timer_d     = timer_q;
      err_d       = err_q;
`endif

      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               mul_a_d = mem_q[rd_ptr_q][15:8];
               mul_b_d = mem_q[rd_ptr_q][7:0];
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
`ifdef KARATSUBA_DISPATCH_TIMEOUT_EN
            timer_d = '0;
`endif
         end
         WAIT: begin
            if (bus.mul_done) begin
               out_res_d   = bus.mul_res;
               out_valid_d = 1'b1;
               state_d     = HOLD;
            end
`ifdef KARATSUBA_DISPATCH_TIMEOUT_EN
            // A multiplier that never answers costs this one pair, not the whole queue.
            else if (timer_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
`endif
         end
         HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (push) begin
         mem_d[wr_ptr_q] = {bus.in_a, bus.in_b};
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State register; reset drops both the queue and any in-flight pair.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         out_valid_q <= 1'b0;
         out_res_q   <= '0;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         out_valid_q <= out_valid_d;
         out_res_q   <= out_res_d;
      end
   end

`ifdef KARATSUBA_DISPATCH_TIMEOUT_EN
   // Watchdog counter and sticky error flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q <= '0;
         err_q   <= 1'b0;
      end else begin
         timer_q <= timer_d;
         err_q   <= err_d;
      end
   end
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
`endif

   // Start is decoded from the state flop so it is exactly one cycle wide.
   assign bus.mul_start = (state_q == ISSUE);
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_res   = out_res_q;
   assign bus.count     = count_q;
endmodule

// File: tb/tb_karatsuba_dispatch.sv
module tb_karatsuba_dispatch;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;
   localparam int LAT     = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;

   karatsuba_dispatch_if #(.DEPTH(DEPTH)) bus ();

   karatsuba_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int n_out = 0;
   int n_start = 0;
   int n_wide = 0;
   bit start_prev = 1'b0;
   int unsigned exp_q [$];

   // behavioural multiplier controls
   int          mcnt = 0;
   logic [15:0] mres = '0;
   bit          mul_en = 1'b1;
   int          stray_req = 0;
   int          stray_ack = 0;

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
      int  tries = 0;
      bit  ok    = 1'b0;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_valid = 1'b1;
      do begin
         ok = bus.in_ready;
         step();
         tries++;
      end while (!ok && tries < 200);
      bus.in_valid = 1'b0;
      if (!ok) timeout_fail("push");
   endtask

   task automatic wait_outs(input int target, input int lim);
      int k = 0;
      while (n_out < target && k < lim) begin
         step();
         k++;
      end
      if (n_out < target) timeout_fail("wait_out");
   endtask

   task automatic wait_start(input int lim);
      int k = 0;
      while (!bus.mul_start && k < lim) begin
         step();
         k++;
      end
      if (!bus.mul_start) timeout_fail("wait_start");
   endtask

   // Multiplier stand-in: DONE with the true product LAT cycles after START; stray pulses on request.
   always @(posedge clk) begin
      #2;
      bus.mul_done = 1'b0;
      if (mcnt > 0) begin
         mcnt--;
         if (mcnt == 0) begin
            bus.mul_done = 1'b1;
            bus.mul_res  = mres;
         end
      end
      if (stray_req != stray_ack) begin
         stray_ack    = stray_req;
         bus.mul_done = 1'b1;
         bus.mul_res  = 16'hBEEF;
      end
      if (bus.mul_start && mul_en) begin
         mcnt = LAT;
         mres = 16'(bus.mul_a) * 16'(bus.mul_b);
      end
   end

   // Scoreboard: every accepted pair owes one product, in push order.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(int'(bus.in_a) * int'(bus.in_b));
         if (bus.out_valid && bus.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_unexpected: got %0d expected none", bus.out_res);
            end else begin
               check("sb_product", 32'(bus.out_res), exp_q.pop_front());
            end
         end
         if (bus.mul_start) begin
            n_start++;
            if (start_prev) n_wide++;
         end
         start_prev = bus.mul_start;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time budget");
      $fatal(1, "global timeout");
   end

   initial begin
      vec_t        tbl [5];
      logic [15:0] r;
      int          s0;
      int          o0;
      int          acc;
      int          sent;
      int          cyc;

      tbl[0] = '{a: 8'd12,  b: 8'd13,  exp: 16'd156};
      tbl[1] = '{a: 8'd255, b: 8'd255, exp: 16'd65025};
      tbl[2] = '{a: 8'd0,   b: 8'd200, exp: 16'd0};
      tbl[3] = '{a: 8'd1,   b: 8'd1,   exp: 16'd1};
      tbl[4] = '{a: 8'd170, b: 8'd3,   exp: 16'd510};

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;
      bus.mul_done  = 1'b0;
      bus.mul_res   = '0;

      // reset state
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();
      check("rst_in_ready",  32'(bus.in_ready), 1);
      check("rst_mul_start", 32'(bus.mul_start), 0);
      check("rst_mul_a",     32'(bus.mul_a), 0);
      check("rst_mul_b",     32'(bus.mul_b), 0);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_out_res",   32'(bus.out_res), 0);
      check("rst_count",     32'(bus.count), 0);
      check("rst_err",       32'(bus.err), 0);

      // table-driven single products, including edge operands
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s0 = n_start;
         push_pair(tbl[i].a, tbl[i].b);
         check("push_count", 32'(bus.count), 1);
         wait_outs(n_out + 1, 60);
         check("tbl_res", 32'(bus.out_res), 32'(tbl[i].exp));
         if (i == 0) check("one_start", 32'(n_start - s0), 1);
      end

      // stray DONE in IDLE
      r  = bus.out_res;
      o0 = n_out;
      stray_req++;
      repeat (4) step();
      check("stray_idle_valid", 32'(bus.out_valid), 0);
      check("stray_idle_res",   32'(bus.out_res), 32'(r));
      check("stray_idle_outs",  32'(n_out), 32'(o0));

      // stray DONE in HOLD
      bus.out_ready = 1'b0;
      push_pair(8'd7, 8'd9);
      cyc = 0;
      while (!bus.out_valid && cyc < 60) begin step(); cyc++; end
      check("hold_res", 32'(bus.out_res), 63);
      stray_req++;
      repeat (4) step();
      check("stray_hold_valid", 32'(bus.out_valid), 1);
      check("stray_hold_res",   32'(bus.out_res), 63);
      bus.out_ready = 1'b1;
      wait_outs(n_out + 1, 20);
      step();
      check("hold_release", 32'(bus.out_valid), 0);

      // backpressure: 8 back-to-back attempts, 5 fit
      bus.out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
         bus.in_a     = 8'(i + 2);
         bus.in_b     = 8'(i + 3);
         bus.in_valid = 1'b1;
         if (bus.in_ready) acc++;
         step();
      end
      bus.in_valid = 1'b0;
      check("bp_accepted", 32'(acc), 5);
      repeat (20) step();
      check("bp_count",     32'(bus.count), 4);
      check("bp_in_ready",  32'(bus.in_ready), 0);
      check("bp_out_valid", 32'(bus.out_valid), 1);
      bus.out_ready = 1'b1;
      wait_outs(n_out + 5, 200);
      check("bp_drained", 32'(exp_q.size()), 0);

      // reset two cycles after START, DONE arrives afterwards
      push_pair(8'd9, 8'd9);
      wait_start(20);
      repeat (2) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
      o0 = n_out;
      repeat (10) step();
      check("mr_out_valid", 32'(bus.out_valid), 0);
      check("mr_out_res",   32'(bus.out_res), 0);
      check("mr_count",     32'(bus.count), 0);
      check("mr_mul_a",     32'(bus.mul_a), 0);
      check("mr_mul_b",     32'(bus.mul_b), 0);
      check("mr_in_ready",  32'(bus.in_ready), 1);
      check("mr_outs",      32'(n_out), 32'(o0));

      // randomized traffic against the product queue
      sent = 0;
      cyc  = 0;
      o0   = n_out;
      while ((sent < 40 || n_out < o0 + 40) && cyc < 4000) begin
         bus.in_valid  = (sent < 40) && ($urandom_range(0, 2) != 0);
         bus.in_a      = 8'($urandom);
         bus.in_b      = 8'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         if (bus.in_valid && bus.in_ready) sent++;
         step();
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      if (n_out < o0 + 40) timeout_fail("random_drain");
      repeat (3) step();
      check("rand_queue_empty", 32'(exp_q.size()), 0);

`ifdef KARATSUBA_DISPATCH_TIMEOUT_EN
      // watchdog: first pair never answered, second one is
      mul_en = 1'b0;
      push_pair(8'd20, 8'd30);
      wait_start(20);
      push_pair(8'd5, 8'd6);
      repeat (15) step();
      check("wd_err_early", 32'(bus.err), 0);
      mul_en = 1'b1;
      step();
      check("wd_err_set", 32'(bus.err), 1);
      check("wd_no_valid", 32'(bus.out_valid), 0);
      void'(exp_q.pop_front());
      wait_outs(n_out + 1, 60);
      check("wd_second", 32'(bus.out_res), 30);
      repeat (3) step();
      check("wd_err_sticky", 32'(bus.err), 1);
`endif

      check("start_width", 32'(n_wide), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
